// File: rtl/mnist_infer_sched.sv
`timescale 1ns/1ps
// mnist_infer_sched
// -----------------------------------------------------------------------------
// Round-robin scheduler that shares one mnist_model inference engine between
// N_REQ requesters. Each job grants one requester, latches its binary image,
// pulses the engine start, waits for the engine result (or a watchdog
// timeout) and then offers the digit, tagged with the requester ID, on a
// valid/ready result port.
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   req             per-requester level request, held until its ack
//   req_img         requester i image at bits [i*IMG_W +: IMG_W]
//   req_ack         one-cycle pulse: image latched, requester may drop req
//   eng_image       image to engine, stable from LAUNCH through WAIT
//   eng_start       one-cycle engine start pulse
//   eng_digit       engine result digit
//   eng_valid       engine result valid (level)
//   res_valid       result available
//   res_ready       consumer accepts the result
//   res_id          requester that owns the result
//   res_digit       classified digit, 4'hF on timeout
//   res_timeout     job aborted by the watchdog
//   busy            high in any state other than IDLE
//   job_cnt         number of accepted results (wraps)
//   dbg_state       current FSM state (IDLE=0, LAUNCH=1, WAIT=2, RESP=3)
//
// Result handshake: res_valid rises when the result is ready and then
// res_id/res_digit/res_timeout stay constant; the transfer happens on the
// rising edge where res_valid and res_ready are both high, after which
// res_valid drops. res_valid never depends combinationally on res_ready.
// -----------------------------------------------------------------------------
module mnist_infer_sched #(
  parameter int N_REQ   = 4,
  parameter int ID_W    = 2,
  parameter int IMG_W   = 784,
  parameter int TIMEOUT = 4096
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*IMG_W-1:0] req_img,
  output logic [N_REQ-1:0]       req_ack,
  output logic [IMG_W-1:0]       eng_image,
  output logic                   eng_start,
  input  logic [3:0]             eng_digit,
  input  logic                   eng_valid,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [ID_W-1:0]        res_id,
  output logic [3:0]             res_digit,
  output logic                   res_timeout,
  output logic                   busy,
  output logic [15:0]            job_cnt,
  output logic [1:0]             dbg_state
);

  localparam int WCNT_W = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t              state_q;
  logic [ID_W-1:0]     last_q;
  logic [WCNT_W-1:0]   wcnt_q;

  // Grant candidate computed from the current request vector.
  logic                grant_vld_d;
  logic [ID_W-1:0]     grant_id_d;
  logic [IMG_W-1:0]    grant_img_d;
  int                  scan_idx;
  logic [N_REQ-1:0]    scan_req;

  // Round-robin search: start just after the last served requester and
  // wrap, so the requester served most recently has the lowest priority.
  always_comb begin
    grant_vld_d = 1'b0;
    grant_id_d  = '0;
    scan_idx    = 0;
    scan_req    = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      scan_idx = (int'(last_q) + k) % N_REQ;
      scan_req = req >> scan_idx;
      if (!grant_vld_d && scan_req[0]) begin
        grant_vld_d = 1'b1;
        grant_id_d  = ID_W'(scan_idx);
      end
    end
    grant_img_d = IMG_W'(req_img >> (int'(grant_id_d) * IMG_W));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      last_q      <= ID_W'(N_REQ - 1);
      wcnt_q      <= '0;
      req_ack     <= '0;
      eng_image   <= '0;
      eng_start   <= 1'b0;
      res_valid   <= 1'b0;
      res_id      <= '0;
      res_digit   <= 4'h0;
      res_timeout <= 1'b0;
      busy        <= 1'b0;
      job_cnt     <= 16'd0;
    end else begin
      // Both pulses last exactly one cycle.
      req_ack   <= '0;
      eng_start <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (grant_vld_d) begin
            eng_image <= grant_img_d;
            res_id    <= grant_id_d;
            req_ack   <= N_REQ'(1) << grant_id_d;
            eng_start <= 1'b1;
            busy      <= 1'b1;
            state_q   <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          wcnt_q  <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          wcnt_q <= wcnt_q + WCNT_W'(1);
          // First WAIT cycle is blanked: a valid still high from the
          // previous job must not be taken as this job's result.
          if (eng_valid && (wcnt_q != '0)) begin
            res_digit   <= eng_digit;
            res_timeout <= 1'b0;
            res_valid   <= 1'b1;
            state_q     <= S_RESP;
          end else if (wcnt_q == WCNT_W'(TIMEOUT - 1)) begin
            res_digit   <= 4'hF;
            res_timeout <= 1'b1;
            res_valid   <= 1'b1;
            state_q     <= S_RESP;
          end
        end
        S_RESP: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            job_cnt   <= job_cnt + 16'd1;
            last_q    <= res_id;
            busy      <= 1'b0;
            state_q   <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign dbg_state = state_q;

endmodule

// File: tb/tb_mnist_infer_sched.sv
`timescale 1ns/1ps
// Testbench for mnist_infer_sched (N_REQ=4, TIMEOUT=16).
// A small engine model answers eng_start after a configurable latency; each
// job is driven by do_job, which checks grant, image, latency and result
// against expectations derived from the round-robin and watchdog rules.
module tb_mnist_infer_sched;

  localparam int N_REQ   = 4;
  localparam int ID_W    = 2;
  localparam int IMG_W   = 784;
  localparam int TIMEOUT = 16;

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------------------------------------------------------- DUT
  logic [N_REQ-1:0]       req = '0;
  logic [N_REQ*IMG_W-1:0] req_img;
  logic [N_REQ-1:0]       req_ack;
  logic [IMG_W-1:0]       eng_image;
  logic                   eng_start;
  logic [3:0]             eng_digit = 4'h0;
  logic                   eng_valid = 1'b0;
  logic                   res_valid;
  logic                   res_ready = 1'b0;
  logic [ID_W-1:0]        res_id;
  logic [3:0]             res_digit;
  logic                   res_timeout;
  logic                   busy;
  logic [15:0]            job_cnt;
  logic [1:0]             dbg_state;

  logic [IMG_W-1:0] img [N_REQ];

  always_comb begin
    req_img = '0;
    for (int i = 0; i < N_REQ; i++) req_img[i*IMG_W +: IMG_W] = img[i];
  end

  mnist_infer_sched #(
    .N_REQ(N_REQ), .ID_W(ID_W), .IMG_W(IMG_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .req_img(req_img), .req_ack(req_ack),
    .eng_image(eng_image), .eng_start(eng_start), .eng_digit(eng_digit),
    .eng_valid(eng_valid), .res_valid(res_valid), .res_ready(res_ready),
    .res_id(res_id), .res_digit(res_digit), .res_timeout(res_timeout),
    .busy(busy), .job_cnt(job_cnt), .dbg_state(dbg_state)
  );

  // ---------------------------------------------------------------- engine model
  // Configuration is captured when eng_start is seen. lat<0 means never answer.
  // Valid is a level that stays high after a result; a normal engine clears it
  // on start, a "stale" engine keeps it through the first two cycles.
  int         cfg_lat = -1;
  logic [3:0] cfg_dig = 4'h0;
  bit         cfg_stale = 1'b0;
  int         e_lat = -1;
  logic [3:0] e_dig = 4'h0;
  bit         e_stale = 1'b0;
  int         ecyc = -1;

  always @(negedge clk) begin
    if (rst) begin
      eng_valid = 1'b0;
      eng_digit = 4'h0;
      ecyc = -1;
    end else begin
      if (eng_start) begin
        ecyc = 0; e_lat = cfg_lat; e_dig = cfg_dig; e_stale = cfg_stale;
      end else if (ecyc >= 0) begin
        ecyc++;
      end
      if (ecyc == 0 && !e_stale) eng_valid = 1'b0;
      if (ecyc == 2 && e_stale) eng_valid = 1'b0;
      if (ecyc >= 0 && e_lat >= 0 && ecyc == e_lat) begin
        eng_valid = 1'b1;
        eng_digit = e_dig;
        ecyc = -1;
      end
    end
  end

  // ---------------------------------------------------------------- scoreboard
  int checks = 0;
  int failures = 0;
  int m_last = N_REQ - 1;
  int m_cnt = 0;
  int last_grant_cyc = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic check_img(input string name, input logic [IMG_W-1:0] got, input logic [IMG_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: image differs, got %h expected %h", name, got[127:0], exp[127:0]);
    end
  endtask

  // Next requester by round-robin from the last served one.
  function automatic int rr_pick(input int last, input logic [N_REQ-1:0] r);
    for (int k = 1; k <= N_REQ; k++) begin
      int i;
      i = (last + k) % N_REQ;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [IMG_W-1:0] rand_img();
    logic [IMG_W-1:0] v;
    v = '0;
    for (int i = 0; i < 25; i++) v = {v[IMG_W-33:0], 32'($urandom)};
    return v;
  endfunction

  task automatic randomize_imgs();
    for (int i = 0; i < N_REQ; i++) img[i] = rand_img();
  endtask

  task automatic check_reset_outs(input string name);
    check({name, " outs"},
          {2'b0, req_ack, eng_start, res_valid, res_timeout, busy, res_id, res_digit, job_cnt},
          32'h0);
    check_img({name, " img"}, eng_image, '0);
  endtask

  // One complete job. Called and returning at a falling edge.
  task automatic do_job(input string tag, input logic [N_REQ-1:0] req_set,
                        input logic [N_REQ-1:0] keep, input logic [N_REQ-1:0] extra,
                        input int lat, input logic [3:0] dig, input bit stale,
                        input int rdy_dly, input int exp_id,
                        input logic [3:0] exp_dig, input bit exp_to);
    bit seen;
    int k, exp_k;
    logic [IMG_W-1:0] exp_img;
    logic [N_REQ-1:0] exp_ack;
    logic [12:0] got_h, exp_h;
    cfg_lat = lat; cfg_dig = dig; cfg_stale = stale;
    res_ready = 1'b0;
    randomize_imgs();
    req = req | req_set;
    seen = 1'b0;
    for (int n = 0; n < 8 && !seen; n++) begin
      @(negedge clk);
      if (req_ack != '0) seen = 1'b1;
    end
    check({tag, " grant_seen"}, 32'(seen), 32'd1);
    if (!seen) return;
    last_grant_cyc = cyc;
    exp_ack = '0;
    exp_ack[exp_id] = 1'b1;
    check({tag, " ack"}, 32'(req_ack), 32'(exp_ack));
    check({tag, " start_with_ack"}, 32'(eng_start), 32'd1);
    check({tag, " busy"}, 32'(busy), 32'd1);
    exp_img = img[exp_id];
    check_img({tag, " eng_image"}, eng_image, exp_img);
    req[exp_id] = 1'b0;
    req = (req & keep) | extra;
    randomize_imgs();
    if (lat >= 0 && lat <= TIMEOUT) exp_k = (lat + 1 > 3) ? lat + 1 : 3;
    else exp_k = TIMEOUT + 1;
    k = 0;
    seen = 1'b0;
    while (!seen && k < TIMEOUT + 10) begin
      @(negedge clk);
      k++;
      if (res_valid) seen = 1'b1;
      else check({tag, " wait_quiet"},
                 {28'd0, req_ack != '0, eng_start, eng_image !== exp_img, busy}, 32'h1);
    end
    check({tag, " res_seen"}, 32'(seen), 32'd1);
    if (!seen) return;
    check({tag, " latency"}, 32'(k), 32'(exp_k));
    check({tag, " res_id"}, 32'(res_id), 32'(exp_id));
    check({tag, " res_digit"}, 32'(res_digit), 32'(exp_dig));
    check({tag, " res_timeout"}, 32'(res_timeout), 32'(exp_to));
    exp_h = {1'b1, ID_W'(exp_id), exp_dig, exp_to, 4'b0000, 1'b1};
    repeat (rdy_dly) begin
      @(negedge clk);
      got_h = {res_valid, res_id, res_digit, res_timeout, req_ack, busy};
      check({tag, " hold"}, 32'(got_h), 32'(exp_h));
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    m_cnt = (m_cnt + 1) % 65536;
    m_last = exp_id;
    check({tag, " res_valid_drop"}, 32'(res_valid), 32'd0);
    check({tag, " idle_busy"}, 32'(busy), 32'd0);
    check({tag, " job_cnt"}, 32'(job_cnt), 32'(m_cnt));
  endtask

  // ---------------------------------------------------------------- vectors
  typedef struct {
    logic [N_REQ-1:0] rs;
    logic [N_REQ-1:0] keep;
    logic [N_REQ-1:0] extra;
    int               lat;
    logic [3:0]       dig;
    bit               stale;
    int               rdy;
    int               exp_id;
    logic [3:0]       exp_dig;
    bit               exp_to;
  } vec_t;

  vec_t tbl[17];

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [N_REQ-1:0] rs, ex;
    int lat, rdy, id, t0, n;
    logic [3:0] dig;
    bit to, seen;

    // all requesters held: grant order 0,1,2,3,0, engine returns id+1
    tbl[0]  = '{4'b1111, 4'b1111, 4'b0000,  0, 4'd1, 1'b0, 0, 0, 4'd1, 1'b0};
    tbl[1]  = '{4'b1111, 4'b1111, 4'b0000,  1, 4'd2, 1'b0, 1, 1, 4'd2, 1'b0};
    tbl[2]  = '{4'b1111, 4'b1111, 4'b0000,  2, 4'd3, 1'b0, 0, 2, 4'd3, 1'b0};
    tbl[3]  = '{4'b1111, 4'b1111, 4'b0000,  5, 4'd4, 1'b0, 2, 3, 4'd4, 1'b0};
    tbl[4]  = '{4'b1111, 4'b0000, 4'b0000, 10, 4'd1, 1'b0, 0, 0, 4'd1, 1'b0};
    // single job, digit 7 after 10 cycles
    tbl[5]  = '{4'b0001, 4'b1111, 4'b0000, 10, 4'd7, 1'b0, 0, 0, 4'd7, 1'b0};
    // leaves valid high with digit 2, next job must ignore it
    tbl[6]  = '{4'b0100, 4'b1111, 4'b0000,  4, 4'd2, 1'b0, 0, 2, 4'd2, 1'b0};
    tbl[7]  = '{4'b0010, 4'b1111, 4'b0000,  6, 4'd4, 1'b1, 0, 1, 4'd4, 1'b0};
    // watchdog: never valid, valid exactly at the last cycle, one cycle late
    tbl[8]  = '{4'b1000, 4'b1111, 4'b0000, -1, 4'd0, 1'b0, 0, 3, 4'hF, 1'b1};
    tbl[9]  = '{4'b0001, 4'b1111, 4'b0000, 16, 4'd9, 1'b0, 0, 0, 4'd9, 1'b0};
    tbl[10] = '{4'b0001, 4'b1111, 4'b0000, 17, 4'd9, 1'b0, 1, 0, 4'hF, 1'b1};
    // backpressure with req[2] pending, then requester 2 served
    tbl[11] = '{4'b0010, 4'b1111, 4'b0100,  3, 4'd5, 1'b0, 20, 1, 4'd5, 1'b0};
    tbl[12] = '{4'b0000, 4'b1111, 4'b0000,  2, 4'd6, 1'b0, 0, 2, 4'd6, 1'b0};
    // out-of-range digit passes through
    tbl[13] = '{4'b1000, 4'b1111, 4'b0000,  1, 4'hC, 1'b0, 0, 3, 4'hC, 1'b0};
    // wrap of the search pointer
    tbl[14] = '{4'b0101, 4'b1111, 4'b0000,  0, 4'd8, 1'b0, 0, 0, 4'd8, 1'b0};
    tbl[15] = '{4'b0000, 4'b1111, 4'b0000,  2, 4'd3, 1'b0, 0, 2, 4'd3, 1'b0};
    tbl[16] = '{4'b1001, 4'b0000, 4'b0000,  0, 4'd0, 1'b0, 1, 3, 4'd0, 1'b0};

    randomize_imgs();
    rst = 1'b1;
    @(negedge clk);
    check_reset_outs("reset");
    @(negedge clk);
    rst = 1'b0;
    m_last = N_REQ - 1;
    m_cnt = 0;

    for (int i = 0; i < 17; i++) begin
      do_job($sformatf("vec%0d", i), tbl[i].rs, tbl[i].keep, tbl[i].extra,
             tbl[i].lat, tbl[i].dig, tbl[i].stale, tbl[i].rdy,
             tbl[i].exp_id, tbl[i].exp_dig, tbl[i].exp_to);
    end

    // minimum job period: back-to-back jobs with immediate engine valid
    do_job("minper_a", 4'b0001, 4'b1111, 4'b0000, 0, 4'd3, 1'b0, 0, 0, 4'd3, 1'b0);
    t0 = last_grant_cyc;
    do_job("minper_b", 4'b0010, 4'b1111, 4'b0000, 0, 4'd6, 1'b0, 0, 1, 4'd6, 1'b0);
    check("min_period", 32'(last_grant_cyc - t0), 32'd5);

    // reset three cycles after start, in the middle of WAIT
    cfg_lat = -1; cfg_stale = 1'b0;
    req = 4'b0100;
    seen = 1'b0;
    for (n = 0; n < 8 && !seen; n++) begin
      @(negedge clk);
      if (eng_start) seen = 1'b1;
    end
    check("midrst grant", 32'(req_ack), 32'h4);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    req = '0;
    #1;
    check_reset_outs("midrst");
    @(negedge clk);
    rst = 1'b0;
    m_last = N_REQ - 1;
    m_cnt = 0;
    repeat (3) begin
      @(negedge clk);
      check("midrst quiet", {30'd0, res_valid, busy}, 32'h0);
    end
    do_job("post_rst", 4'b1111, 4'b0000, 4'b0000, 2, 4'd5, 1'b0, 0, 0, 4'd5, 1'b0);

    // randomized jobs against the round-robin / watchdog rules
    for (int j = 0; j < 40; j++) begin
      rs = N_REQ'($urandom_range(0, 15));
      ex = ($urandom_range(0, 3) == 0) ? N_REQ'($urandom_range(0, 15)) : '0;
      if ((req | rs) == '0) rs = N_REQ'(1) << $urandom_range(0, N_REQ - 1);
      lat = int'($urandom_range(0, 21)) - 1;
      dig = 4'($urandom_range(0, 15));
      rdy = int'($urandom_range(0, 3));
      id  = rr_pick(m_last, req | rs);
      to  = !(lat >= 0 && lat <= TIMEOUT);
      do_job($sformatf("rnd%0d", j), rs, 4'b1111, ex, lat, dig, 1'b0, rdy,
             id, to ? 4'hF : dig, to);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mnist_infer_sched.md
Name: mnist_infer_sched

Overview:
- Round-robin scheduler that shares one mnist_model inference engine among N_REQ requesters.
- Per job: grants one requester, latches its 784-bit binary image, pulses the engine start and waits for engine valid.
- Returns the digit tagged with the requester ID on a valid/ready result port.
- Timeout watchdog guards against a hung engine; a 16-bit job counter supports debug.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- ID_W, 2, requester ID width; must be >= clog2(N_REQ).
- IMG_W, 784, image width in bits (28x28, 1 bit/pixel).
- TIMEOUT, 4096, max WAIT cycles before a job is aborted (>= 4).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- req  in  N_REQ  per-requester job request; level, held until the matching ack.
- req_img  in  N_REQ*IMG_W  requester i image at bits [i*IMG_W +: IMG_W].
- req_ack  out  N_REQ  one-cycle pulse: image latched, requester may drop req.
- eng_image  out  IMG_W  image to engine; stable from LAUNCH through WAIT.
- eng_start  out  1  one-cycle start pulse to engine.
- eng_digit  in  4  engine result.
- eng_valid  in  1  engine result valid (level).
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts the result.
- res_id  out  ID_W  requester that owns the result.
- res_digit  out  4  classified digit; 4'hF on timeout.
- res_timeout  out  1  job aborted by watchdog.
- busy  out  1  high in any state other than IDLE.
- job_cnt  out  16  completed (accepted) results, wraps at 65535->0.

Behaviour:
- Reset (async, any state): state=IDLE; req_ack, eng_start, res_valid, res_timeout, busy = 0; eng_image, res_id, res_digit, job_cnt = 0; round-robin pointer last = N_REQ-1, so requester 0 has first priority. A reset mid-job drops the job silently and returns no result.
- All outputs are registered.
- States: IDLE -> LAUNCH -> WAIT -> RESP -> IDLE.
- IDLE:
  - If req != 0, select the first set bit searching (last+1) mod N_REQ upward with wrap.
  - On that edge: latch req_img slice into eng_image, set res_id = winner, pulse req_ack[winner], go to LAUNCH.
  - Result: ack and eng_start are both high during the first LAUNCH cycle, 1 cycle after req is sampled.
  - If req == 0, stay in IDLE.
- LAUNCH: eng_start=1 for exactly this cycle; clear wait counter wcnt=0; go to WAIT.
- WAIT:
  - wcnt increments every cycle.
  - eng_valid is ignored while wcnt==0 (blanking for a stale valid from the previous job).
  - If eng_valid=1 and wcnt>=1: res_digit=eng_digit, res_timeout=0, go to RESP.
  - Else if wcnt==TIMEOUT-1: res_digit=4'hF, res_timeout=1, go to RESP.
  - If valid and timeout occur in the same cycle, valid wins.
- RESP:
  - res_valid=1; res_id, res_digit, res_timeout held stable until the handshake.
  - On res_valid & res_ready: res_valid=0, job_cnt+1 (timeouts included), last=res_id, go to IDLE.
  - res_ready high on the cycle RESP is entered completes the handshake that cycle (minimum 1 RESP cycle).
- req changes during LAUNCH/WAIT/RESP are ignored; new requests wait for IDLE.
- A req dropped before grant is never acked.
- The engine digit is passed through unchecked; values >9 are not trapped.
- Minimum job period with an immediate engine valid and res_ready tied high: 5 cycles (IDLE, LAUNCH, WAIT x2, RESP).

Test Plan:
- Single job: rst pulse, req=4'b0001 with image A; engine returns digit 7 on valid 10 cycles after start -> req_ack[0] and eng_start pulse once each, same cycle; then res_valid=1, res_id=0, res_digit=7, res_timeout=0; job_cnt=1.
- Round robin: req=4'b1111 held, engine returns index+1 -> grant order 0,1,2,3,0; res_id follows that order; each req_ack is 1 cycle; job_cnt=5 after five accepts.
- Stale valid: engine holds eng_valid=1 with digit 2 from the previous job, drops it in the cycle after start, then returns digit 4 -> res_digit=4, not 2.
- Timeout: TIMEOUT=16, engine never asserts valid -> RESP entered at wcnt=15 with res_digit=4'hF, res_timeout=1; next req is still granted.
- Backpressure: res_ready=0 for 20 cycles with req[2] pending -> res_* held constant, no req_ack[2], busy=1; raising res_ready returns to IDLE and then acks requester 2.
- Reset mid-WAIT: assert rst 3 cycles after eng_start -> all outputs 0 immediately, no res_valid, job_cnt=0; requester 0 is granted first after release.
